// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one physical-memory line port between the
// I-cache miss port (a, read only) and the D-cache miss/writeback port (b).
// One line transaction is in flight at a time. The winning request is
// latched so that memory sees a stable address and data for the whole
// transfer. A saturating counter records cycles in which one port is
// waiting while the other port owns, or is being handed, the memory.
//
// Optional build macro ARB_ROUND_ROBIN_EN: when it is defined, an IDLE
// conflict goes to the port that did not win the previous IDLE grant.
// When it is undefined, port b always wins an IDLE conflict.
// A completion handoff to the waiting port happens in both builds.

module cache_mem_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_a,
    input  logic [ADDR_W-1:0] address_a,
    output logic              resp_a,
    output logic [LINE_W-1:0] rdata_a,
    input  logic              read_b,
    input  logic              write_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [LINE_W-1:0] wdata_b,
    output logic              resp_b,
    output logic [LINE_W-1:0] rdata_b,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [LINE_W-1:0] pmem_rdata,
    output logic [CNT_W-1:0]  contention_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [ADDR_W-1:0]  address_r;
    logic [LINE_W-1:0]  wdata_r;
    logic               op_write_r;
    logic [CNT_W-1:0]   count_r;
    logic               req_a_s;
    logic               req_b_s;
    logic               pick_b_s;
    logic               grant_a_s;
    logic               grant_b_s;
    logic               contend_s;

    assign req_a_s = read_a;
    assign req_b_s = read_b | write_b;

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant: 0 = a won the last IDLE arbitration, 1 = b did.
    // A completion handoff is not an arbitration decision and leaves it alone.
    logic last_grant_r;

    assign pick_b_s = ~last_grant_r;

    // Remember which port won the most recent grant issued from IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= 1'b0;
        end else if ((state_r == IDLE) && grant_b_s) begin
            last_grant_r <= 1'b1;
        end else if ((state_r == IDLE) && grant_a_s) begin
            last_grant_r <= 1'b0;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    assign pick_b_s = 1'b1;
`endif

    // Next-state selection: IDLE arbitration and completion handoff
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_a_s && req_b_s) begin
                    state_s = pick_b_s ? SERVE_B : SERVE_A;
                end else if (req_a_s) begin
                    state_s = SERVE_A;
                end else if (req_b_s) begin
                    state_s = SERVE_B;
                end else begin
                    state_s = IDLE;
                end
            end
            SERVE_A: begin
                if (pmem_resp) begin
                    state_s = req_b_s ? SERVE_B : IDLE;
                end else begin
                    state_s = SERVE_A;
                end
            end
            SERVE_B: begin
                if (pmem_resp) begin
                    state_s = req_a_s ? SERVE_A : IDLE;
                end else begin
                    state_s = SERVE_B;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // A grant is any edge that enters a SERVE state from elsewhere; the same
    // port is never re-entered directly, so this also covers handoffs.
    assign grant_a_s = (state_s == SERVE_A) && (state_r != SERVE_A);
    assign grant_b_s = (state_s == SERVE_B) && (state_r != SERVE_B);

    // A port waits while the other one owns the memory or is taking it this edge
    assign contend_s = (req_a_s && (state_r != SERVE_A) && ((state_r == SERVE_B) || grant_b_s)) ||
                       (req_b_s && (state_r != SERVE_B) && ((state_r == SERVE_A) || grant_a_s));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the winning request so memory sees it unchanged for the whole transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_r  <= {ADDR_W{1'b0}};
            wdata_r    <= {LINE_W{1'b0}};
            op_write_r <= 1'b0;
        end else if (grant_a_s) begin
            address_r  <= address_a;
            op_write_r <= 1'b0;
        end else if (grant_b_s) begin
            address_r  <= address_b;
            wdata_r    <= wdata_b;
            op_write_r <= write_b;
        end else begin
            address_r  <= address_r;
            op_write_r <= op_write_r;
        end
    end

    // Saturating contention counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (contend_s && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Strobes decode the registered state; completions are the memory pulse
    // qualified by the owning port, and read data passes straight through.
    assign pmem_read        = (state_r == SERVE_A) || ((state_r == SERVE_B) && !op_write_r);
    assign pmem_write       = (state_r == SERVE_B) && op_write_r;
    assign pmem_address     = address_r;
    assign pmem_wdata       = wdata_r;
    assign resp_a           = pmem_resp && (state_r == SERVE_A);
    assign resp_b           = pmem_resp && (state_r == SERVE_B);
    assign rdata_a          = pmem_rdata;
    assign rdata_b          = pmem_rdata;
    assign contention_count = count_r;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter. A transaction-level model (who owns memory,
// how long it has owned it, what was latched) predicts every output each
// cycle and also plays the memory, so the bench never waits on the DUT.
// Honour ARB_ROUND_ROBIN_EN the same way as the design.

module tb_cache_mem_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          read_a;
    logic [AW-1:0] address_a;
    logic          resp_a;
    logic [LW-1:0] rdata_a;
    logic          read_b;
    logic          write_b;
    logic [AW-1:0] address_b;
    logic [LW-1:0] wdata_b;
    logic          resp_b;
    logic [LW-1:0] rdata_b;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic          pmem_resp;
    logic [LW-1:0] pmem_rdata;
    logic [CW-1:0] contention_count;

    cache_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_a(read_a), .address_a(address_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .address_b(address_b), .wdata_b(wdata_b),
        .resp_b(resp_b), .rdata_b(rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
        .contention_count(contention_count)
    );

    initial forever #5 clk = ~clk;

    // model: owner 0 = nobody, 1 = port a, 2 = port b
    int            owner;
    int            age;
    int            mem_lat;
    logic          resp_due;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    logic          m_wr;
    int            m_last;
    int            m_cnt;

    int n_cmp;
    int n_bad;
    int cyc;
    int nra;
    int nrb;
    int ra_cyc;
    int c0;
    logic da;
    logic db;
    logic [LW-1:0] wline;

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        owner = 0; age = 0; resp_due = 1'b0;
        m_addr = '0; m_wdata = '0; m_wr = 1'b0; m_last = 1; m_cnt = 0;
    endtask

    // Advance the model across one rising edge using the inputs held during the cycle
    task automatic model_edge();
        int  nxt;
        bit  wa;
        bit  wb;
        if (!rst_n) begin
            model_reset();
        end else begin
            wa = read_a;
            wb = read_b || write_b;
            nxt = owner;
            if (owner == 0) begin
                if (wa && wb) begin
`ifdef ARB_ROUND_ROBIN_EN
                    nxt = (m_last == 2) ? 1 : 2;
`else
                    nxt = 2;
`endif
                end else if (wa) nxt = 1;
                else if (wb) nxt = 2;
            end else if (pmem_resp) begin
                nxt = (owner == 1) ? (wb ? 2 : 0) : (wa ? 1 : 0);
            end
            if ((wa && owner != 1 && (owner == 2 || nxt == 2)) ||
                (wb && owner != 2 && (owner == 1 || nxt == 1)))
                m_cnt = (m_cnt < (1 << CW) - 1) ? m_cnt + 1 : m_cnt;
            if (nxt != 0 && nxt != owner) begin
                if (nxt == 1) m_addr = address_a;
                else begin
                    m_addr = address_b; m_wdata = wdata_b; m_wr = write_b;
                end
                if (owner == 0) m_last = nxt;
                age = 1;
            end else if (nxt != 0) age++;
            else age = 0;
            owner = nxt;
            resp_due = (owner != 0) && (age == mem_lat);
        end
    endtask

    // One clock: compare at the falling edge, then model + memory + request drops after the rise
    task automatic step();
        logic ea;
        logic eb;
        @(negedge clk);
        ea = pmem_resp && (owner == 1);
        eb = pmem_resp && (owner == 2);
        chk("pmem_read", LW'(pmem_read), LW'((owner == 1) || (owner == 2 && !m_wr)));
        chk("pmem_write", LW'(pmem_write), LW'(owner == 2 && m_wr));
        chk("resp_a", LW'(resp_a), LW'(ea));
        chk("resp_b", LW'(resp_b), LW'(eb));
        chk("pmem_address", LW'(pmem_address), LW'(m_addr));
        chk("pmem_wdata", pmem_wdata, m_wdata);
        chk("contention_count", LW'(contention_count), LW'(m_cnt));
        if (ea) chk("rdata_a", rdata_a, pmem_rdata);
        if (eb) chk("rdata_b", rdata_b, pmem_rdata);
        if (resp_a === 1'b1) begin nra++; ra_cyc = cyc; end
        if (resp_b === 1'b1) nrb++;
        da = ea; db = eb;
        @(posedge clk);
        #1;
        cyc++;
        model_edge();
        if (da) read_a = 1'b0;
        if (db) begin read_b = 1'b0; write_b = 1'b0; end
        pmem_resp = resp_due;
        if (resp_due) for (int i = 0; i < LW / 32; i++) pmem_rdata[i*32 +: 32] = $urandom;
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while ((owner != 0 || read_a || read_b || write_b) && k < max) begin
            step();
            k++;
        end
        if (k >= max) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", max);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        read_a = 1'b0; read_b = 1'b0; write_b = 1'b0; pmem_resp = 1'b0;
        step(); step();
        rst_n = 1'b1;
        nra = 0; nrb = 0;
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; cyc = 0; nra = 0; nrb = 0; ra_cyc = 0;
        mem_lat = 4;
        address_a = '0; address_b = '0; wdata_b = '0; pmem_rdata = '0;
        do_reset();
        chk("reset_pmem_read", LW'(pmem_read), LW'(1'b0));
        chk("reset_pmem_address", LW'(pmem_address), LW'(32'h0));
        chk("reset_count", LW'(contention_count), LW'(4'h0));

        // lone I-fetch, memory latency 4
        mem_lat = 4; read_a = 1'b1; address_a = 32'h0000_0060; c0 = cyc;
        step();
        chk("fetch_strobe", LW'(pmem_read), LW'(1'b1));
        chk("fetch_addr", LW'(pmem_address), LW'(32'h0000_0060));
        wait_idle(20);
        chk("fetch_resp_pulses", LW'(nra), LW'(32'd1));
        chk("fetch_resp_cycle", LW'(ra_cyc - c0), LW'(32'd4));
        chk("fetch_count", LW'(contention_count), LW'(4'h0));

        // lone writeback
        do_reset();
        mem_lat = 3; wline = {8{32'hDEAD_BEEF}};
        write_b = 1'b1; address_b = 32'h0000_0100; wdata_b = wline;
        step();
        chk("wb_strobe", LW'(pmem_write), LW'(1'b1));
        chk("wb_no_read", LW'(pmem_read), LW'(1'b0));
        chk("wb_wdata", pmem_wdata, wline);
        wait_idle(20);
        chk("wb_resp_pulses", LW'(nrb), LW'(32'd1));

        // simultaneous conflict: b first, then a with no idle gap
        do_reset();
        mem_lat = 3;
        read_a = 1'b1; address_a = 32'h0000_0200;
        read_b = 1'b1; address_b = 32'h0000_0300;
        step();
        chk("conflict1_first", LW'(pmem_address), LW'(32'h0000_0300));
        repeat (3) step();
        chk("conflict1_handoff_addr", LW'(pmem_address), LW'(32'h0000_0200));
        chk("conflict1_handoff_read", LW'(pmem_read), LW'(1'b1));
        wait_idle(20);
        chk("conflict1_count", LW'(contention_count), LW'(4'd4));

        // second conflict: round robin flips to a, fixed priority keeps b
        read_a = 1'b1; address_a = 32'h0000_0400;
        read_b = 1'b1; address_b = 32'h0000_0500;
        step();
`ifdef ARB_ROUND_ROBIN_EN
        chk("conflict2_first", LW'(pmem_address), LW'(32'h0000_0400));
`else
        chk("conflict2_first", LW'(pmem_address), LW'(32'h0000_0500));
`endif
        wait_idle(20);
        chk("conflict2_count", LW'(contention_count), LW'(4'd8));

        // reset during SERVE_B, then a pending read_a
        do_reset();
        mem_lat = 6; read_b = 1'b1; address_b = 32'h0000_0600;
        step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_read", LW'(pmem_read), LW'(1'b0));
        chk("rst_mid_write", LW'(pmem_write), LW'(1'b0));
        chk("rst_mid_resp_b", LW'(resp_b), LW'(1'b0));
        chk("rst_mid_addr", LW'(pmem_address), LW'(32'h0));
        model_reset();
        read_b = 1'b0; pmem_resp = 1'b0;
        read_a = 1'b1; address_a = 32'h0000_0700;
        step();
        rst_n = 1'b1;
        step();
        chk("after_rst_read", LW'(pmem_read), LW'(1'b1));
        chk("after_rst_addr", LW'(pmem_address), LW'(32'h0000_0700));
        wait_idle(20);
        chk("after_rst_resp_a", LW'(nra), LW'(32'd1));
        chk("after_rst_no_resp_b", LW'(nrb), LW'(32'd0));

        // long contention saturates the 4-bit counter
        do_reset();
        mem_lat = 25;
        read_a = 1'b1; address_a = 32'h0000_0800;
        read_b = 1'b1; address_b = 32'h0000_0900;
        wait_idle(100);
        chk("saturate_count", LW'(contention_count), LW'(4'hF));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
